// File: rtl/xy_vector_player.sv
// XY vector point player: parses a UART byte stream into a point buffer and replays it to the X/Y DACs every DIV clocks.
// Outputs update 1 clk after a prescaler tick; define LOAD_TIMEOUT_EN to abort stalled loads after TIMEOUT_CYC idle cycles.
module xy_vector_player #(
  parameter int DAC_W       = 8,
  parameter int DEPTH       = 64,
  parameter int DIV         = 64,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             play_en,
  output logic [DAC_W-1:0] xdac,
  output logic [DAC_W-1:0] ydac,
  output logic             blank,
  output logic             frame_start,
  output logic             loading,
  output logic             err
);

  localparam int BPC = (DAC_W <= 8) ? 1 : 2;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int DVW = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, LEN, DATA, MODE} pstate_t;

  pstate_t          state, state_nxt;
  logic [7:0]       n_len;
  logic [7:0]       hi_byte;
  logic [PW-1:0]    wr_idx;
  logic             sel_y, sel_lsb;
  logic [DAC_W-1:0] mem_x [DEPTH];
  logic [DAC_W-1:0] mem_y [DEPTH];
  logic [CW-1:0]    count;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic             dir_up, dir_nxt;
  logic [1:0]       mode;
  logic             done;
  logic [DVW-1:0]   presc;
  logic             blank_q;

  logic len_ok, coord_end, last_byte, timeout;
  logic len_accept, len_err, load_done, mode_wr, data_wr;
  logic m_ping, m_one, cnt_nz, active, hold_last, tick, ptr_last;
  logic [DAC_W-1:0] coord;

  assign len_ok    = (rx_data != 8'd0) && (32'(rx_data) <= DEPTH);
  assign coord_end = (BPC == 1) || sel_lsb;
  assign last_byte = sel_y && coord_end && (32'(wr_idx) == 32'(n_len) - 1);
  // Coordinates arrive MSB byte first; only the low DAC_W bits survive.
  assign coord     = DAC_W'({hi_byte, rx_data});
  assign loading   = (state == DATA);

`ifdef LOAD_TIMEOUT_EN
  logic [31:0] to_cnt;
  assign timeout = ((state == LEN) || (state == DATA)) && !rx_valid &&
                   (to_cnt == 32'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (rx_valid || !((state == LEN) || (state == DATA)))
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 32'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    len_accept = 1'b0;
    len_err    = 1'b0;
    load_done  = 1'b0;
    mode_wr    = 1'b0;
    data_wr    = 1'b0;
    case (state)
      IDLE: if (rx_valid) begin
        if (rx_data == 8'h80)      state_nxt = LEN;
        else if (rx_data == 8'h81) state_nxt = MODE;
      end
      LEN: if (rx_valid) begin
        if (len_ok) begin
          len_accept = 1'b1;
          state_nxt  = DATA;
        end else begin
          len_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DATA: if (rx_valid) begin
        data_wr = 1'b1;
        if (last_byte) begin
          load_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      MODE: if (rx_valid) begin
        mode_wr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n_len   <= '0;
      hi_byte <= '0;
      wr_idx  <= '0;
      sel_y   <= 1'b0;
      sel_lsb <= 1'b0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (len_accept) begin
        n_len   <= rx_data;
        wr_idx  <= '0;
        sel_y   <= 1'b0;
        sel_lsb <= 1'b0;
        count   <= '0;
      end
      if (data_wr) begin
        if (!coord_end) begin
          hi_byte <= rx_data;
          sel_lsb <= 1'b1;
        end else begin
          sel_lsb <= 1'b0;
          sel_y   <= !sel_y;
          if (sel_y) wr_idx <= wr_idx + PW'(1);
        end
      end
      if (load_done) count <= CW'(n_len);
      if (load_done)                err <= 1'b0;
      else if (len_err || timeout)  err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (data_wr && coord_end && !sel_y) mem_x[wr_idx] <= coord;
    if (data_wr && coord_end && sel_y)  mem_y[wr_idx] <= coord;
  end

  assign m_ping    = (mode == 2'd1);
  assign m_one     = (mode == 2'd2);
  assign cnt_nz    = (count != '0);
  assign active    = play_en && cnt_nz && !loading && !(m_one && done);
  assign hold_last = play_en && cnt_nz && !loading && m_one && done;
  // A length byte accepted on a tick cycle zeroes count, so that tick is dropped.
  assign tick      = active && (presc == DVW'(DIV - 1)) && !len_accept;
  assign ptr_last  = (CW'(ptr) == count - CW'(1));
  assign blank     = blank_q || !cnt_nz || loading || !play_en;

  always_comb begin
    ptr_nxt = ptr + PW'(1);
    dir_nxt = dir_up;
    if (m_ping) begin
      if (dir_up) begin
        if (ptr_last) begin
          ptr_nxt = (count == CW'(1)) ? '0 : ptr - PW'(1);
          dir_nxt = (count == CW'(1));
        end
      end else if (ptr == '0) begin
        ptr_nxt = PW'(1);
        dir_nxt = 1'b1;
      end else begin
        ptr_nxt = ptr - PW'(1);
      end
    end else if (ptr_last) begin
      ptr_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xdac        <= '0;
      ydac        <= '0;
      blank_q     <= 1'b1;
      frame_start <= 1'b0;
      ptr         <= '0;
      dir_up      <= 1'b1;
      mode        <= 2'd0;
      done        <= 1'b0;
      presc       <= '0;
    end else begin
      frame_start <= 1'b0;
      // Idle playback rewinds so the next enable starts at point 0.
      if (!active) begin
        presc  <= '0;
        ptr    <= '0;
        dir_up <= 1'b1;
        if (!hold_last) blank_q <= 1'b1;
      end else begin
        presc <= (presc == DVW'(DIV - 1)) ? '0 : presc + DVW'(1);
      end
      if (tick) begin
        xdac        <= mem_x[ptr];
        ydac        <= mem_y[ptr];
        blank_q     <= 1'b0;
        frame_start <= (ptr == '0);
        ptr         <= ptr_nxt;
        dir_up      <= dir_nxt;
        if (m_one && ptr_last) done <= 1'b1;
      end
      if (mode_wr) begin
        mode   <= rx_data[1:0];
        dir_up <= 1'b1;
        done   <= 1'b0;
      end
      if (load_done) begin
        ptr    <= '0;
        dir_up <= 1'b1;
        presc  <= '0;
        done   <= 1'b0;
      end
    end
  end

endmodule
